muxbotones_autorep: RTL

- Successor to the alarm-clock button router.
- Takes raw, bouncing push-buttons: minutes, hours, clock-mode and alarm-mode.
- Synchronises and debounces every button, then decodes the set mode.
- Emits single-cycle increment pulses toward the clock or alarm minute/hour counters, with hold-to-auto-repeat and parametrised timing.
- Sits between the board buttons and the time/alarm counter blocks.

---
 rtl/muxbotones_autorep_if.sv | 23 ++
 rtl/muxbotones_autorep.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muxbotones_autorep_if.sv
// Button-side and counter-side signals of the alarm-clock button router.
// master drives the raw buttons, slave is the router itself.
interface muxbotones_autorep_if;
  logic       bumin;
  logic       buhor;
  logic       brel;
  logic       balar;
  logic       minala;
  logic       horala;
  logic       minreloj;
  logic       horreloj;
  logic [1:0] modo;

  modport master (
    output bumin, buhor, brel, balar,
    input  minala, horala, minreloj, horreloj, modo
  );

  modport slave (
    input  bumin, buhor, brel, balar,
    output minala, horala, minreloj, horreloj, modo
  );
endinterface

// File: rtl/muxbotones_autorep.sv
// Debounced button router with mode decode and hold-to-repeat pulses
// toward the clock/alarm minute and hour counters.
module muxbotones_autorep #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter logic [23:0] REP_DELAY  = 24'd5000000,
  parameter logic [23:0] REP_PERIOD = 24'd2500000,
  parameter int          CNT_W      = 24
) (
  input logic clk,
  input logic rst_n,
  muxbotones_autorep_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    LOCK
  } st_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 16'd1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REP_DELAY - 24'd1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REP_PERIOD - 24'd1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX    = '1;

  logic [3:0]       raw;
  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       deb;
  logic [CNT_W-1:0] dcnt [4];

  assign raw = {bus.balar, bus.brel, bus.buhor, bus.bumin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= '0;
      s2  <= '0;
      deb <= '0;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_LAST) begin
          deb[i]  <= ~deb[i];
          dcnt[i] <= '0;
        end else if (dcnt[i] != C_MAX) begin
          dcnt[i] <= dcnt[i] + C_ONE;
        end
      end
    end
  end

  // mode encoding matches modo: bit0 clock, bit1 alarm
  logic [1:0] cur_mode;
  logic       valid;
  logic [1:0] btn;

  assign cur_mode = {deb[3], deb[2]};
  assign valid    = cur_mode[0] ^ cur_mode[1];
  assign btn      = deb[1:0];

  st_t              st     [2];
  st_t              st_nx  [2];
  logic [CNT_W-1:0] cnt    [2];
  logic [CNT_W-1:0] cnt_nx [2];
  logic [1:0]       lat    [2];
  logic [1:0]       lat_nx [2];
  logic [1:0]       pulse;
  logic [1:0]       route  [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
        lat[i] <= 2'b00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        st[i]  <= st_nx[i];
        cnt[i] <= cnt_nx[i];
        lat[i] <= lat_nx[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_nx[i]  = st[i];
      lat_nx[i] = lat[i];
      cnt_nx[i] = (cnt[i] == C_MAX) ? cnt[i]
                                    : cnt[i] + C_ONE;
      unique case (st[i])
        IDLE: begin
          cnt_nx[i] = '0;
          if (btn[i]) begin
            if (valid) begin
              st_nx[i]  = HOLD;
              lat_nx[i] = cur_mode;
            end else begin
              st_nx[i] = LOCK;
            end
          end
        end
        HOLD: begin
          if (!btn[i]) begin
            st_nx[i] = IDLE;
          end else if (cur_mode != lat[i]) begin
            st_nx[i] = LOCK;
          end else if (cnt[i] == DLY_LAST) begin
            st_nx[i]  = REPEAT;
            cnt_nx[i] = '0;
          end
        end
        REPEAT: begin
          if (!btn[i]) begin
            st_nx[i] = IDLE;
          end else if (cur_mode != lat[i]) begin
            st_nx[i] = LOCK;
          end else if (cnt[i] == PER_LAST) begin
            cnt_nx[i] = '0;
          end
        end
        LOCK: begin
          cnt_nx[i] = '0;
          if (!btn[i]) st_nx[i] = IDLE;
        end
      endcase
    end
  end

  // release wins over mode change: btn gates every pulse term
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pulse[i] = 1'b0;
      route[i] = lat[i];
      unique case (st[i])
        IDLE: begin
          pulse[i] = btn[i] & valid;
          route[i] = cur_mode;
        end
        HOLD: begin
          pulse[i] = btn[i]
                   & (cur_mode == lat[i])
                   & (cnt[i] == DLY_LAST);
        end
        REPEAT: begin
          pulse[i] = btn[i]
                   & (cur_mode == lat[i])
                   & (cnt[i] == PER_LAST);
        end
        LOCK: begin
          pulse[i] = 1'b0;
        end
      endcase
    end
  end

  logic       minala_q;
  logic       horala_q;
  logic       minreloj_q;
  logic       horreloj_q;
  logic [1:0] modo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minala_q   <= 1'b0;
      horala_q   <= 1'b0;
      minreloj_q <= 1'b0;
      horreloj_q <= 1'b0;
      modo_q     <= 2'b00;
    end else begin
      minala_q   <= pulse[0] & route[0][1];
      minreloj_q <= pulse[0] & route[0][0];
      horala_q   <= pulse[1] & route[1][1];
      horreloj_q <= pulse[1] & route[1][0];
      modo_q     <= cur_mode;
    end
  end

  assign bus.minala   = minala_q;
  assign bus.horala   = horala_q;
  assign bus.minreloj = minreloj_q;
  assign bus.horreloj = horreloj_q;
  assign bus.modo     = modo_q;

endmodule
